// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder: FSM state encoding
// and the slice width processed per clock.
package nsa_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int NIBBLE_W = 4;

endpackage

// File: rtl/adder_4bit.sv
// Purely combinational 4-bit ripple slice; the serial adder reuses this single
// instance for every nibble of the operands.
module adder_4bit
   import nsa_pkg::*;
(
   input  logic [NIBBLE_W-1:0] ina,
   input  logic [NIBBLE_W-1:0] inb,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] sum,
   output logic                cout
);

   logic [NIBBLE_W:0] total;

   assign total = {1'b0, ina} + {1'b0, inb} + {{NIBBLE_W{1'b0}}, cin};
   assign sum   = total[NIBBLE_W-1:0];
   assign cout  = total[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock, LSB first, carry held in a
// flop between nibbles; result, carry-out and signed overflow committed with done.
module nibble_serial_adder
   import nsa_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output state_e           state_dbg
);

   // Handshake: an operation is accepted on any rising edge where start=1 and
   // ready=1; ready drops for the NIB RUN cycles and done pulses once on completion.

   localparam int NIB  = WIDTH / NIBBLE_W;
   localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

   state_e            state_q, state_d;
   logic [IDXW-1:0]   idx_q;
   logic [WIDTH-1:0]  a_r, b_r, acc_q, acc_next;
   logic              carry_r;
   logic [WIDTH-1:0]  sum_q;
   logic              cout_q, ovf_q, done_q;
   logic [NIBBLE_W-1:0] nib_a, nib_b, sum4;
   logic              cout4;
   logic              last;

   assign last  = (idx_q == IDXW'(NIB - 1));
   assign nib_a = a_r[NIBBLE_W*idx_q +: NIBBLE_W];
   assign nib_b = b_r[NIBBLE_W*idx_q +: NIBBLE_W];

   adder_4bit u_slice (
      .ina  (nib_a),
      .inb  (nib_b),
      .cin  (carry_r),
      .sum  (sum4),
      .cout (cout4)
   );

   // Accumulator with the current nibble merged in; on the last nibble this is the full sum.
   always_comb begin
      acc_next = acc_q;
      acc_next[NIBBLE_W*idx_q +: NIBBLE_W] = sum4;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last)  state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q   <= '0;
         a_r     <= '0;
         b_r     <= '0;
         acc_q   <= '0;
         carry_r <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            RUN: begin
               acc_q   <= acc_next;
               carry_r <= cout4;
               if (last) begin
                  sum_q  <= acc_next;
                  cout_q <= cout4;
                  ovf_q  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                            (acc_next[WIDTH-1] != a_r[WIDTH-1]);
                  done_q <= 1'b1;
               end else begin
                  idx_q <= idx_q + IDXW'(1);
               end
            end
            default: begin
               if (start) begin
                  a_r     <= a;
                  b_r     <= b;
                  carry_r <= cin;
                  idx_q   <= '0;
                  acc_q   <= '0;
               end
            end
         endcase
      end
   end

   assign ready     = (state_q != RUN);
   assign busy      = (state_q == RUN);
   assign done      = done_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign state_dbg = state_q;

endmodule
